// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// default bit timing shared with the transmitter.
package uart_pkg;

  // Receiver FSM states; PARITY is only reachable when UART_RX_PARITY_EN is defined
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // 10 MHz system clock over 115200 baud
  localparam int UART_CLKS_PER_BIT = 87;

  // Even parity bit for a data word: XOR of all data bits
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Resets to 1 so an idle serial line reads as idle straight out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic q_sync
);

  logic meta_q;

  // Two back-to-back flops give the first stage a full cycle to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      q_sync <= 1'b1;
    end else begin
      meta_q <= d_async;
      q_sync <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// UART receive front-end feeding a FIFO write port.
// Recovers 8N1 frames by mid-bit sampling, writes good bytes as a one-cycle
// strobe, and reports framing / overrun errors as one-cycle pulses.
// Optional feature: define UART_RX_PARITY_EN for an even-parity bit between
// the data bits and the stop bit, reported on Parity_Err.
module uart_rx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      Rx_Serial,
  input  logic                      f_full,
  output logic [UART_DATA_BITS-1:0] Rx_Byte,
  output logic                      Rx_DV,
  output logic                      Rx_Busy,
  output logic                      Frame_Err,
  output logic                      Overrun_Err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                      Parity_Err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                      rx_dv_q, rx_dv_d;
  logic                      busy_q, busy_d;
  logic                      frame_err_q, frame_err_d;
  logic                      overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      parity_err_q, parity_err_d;
`endif

  sync_2ff u_sync (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .d_async (Rx_Serial),
    .q_sync  (rx_s)
  );

  // Next-state and output decode; outputs are registered from the _d values
  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q + CNT_ONE;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    rx_byte_d     = rx_byte_q;
    rx_dv_d       = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_err_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s) state_d = START;
      end

      // Sample the start bit near its centre; a high line here was a glitch
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          state_d = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          shift_d[bit_idx_q] = rx_s;
          clk_cnt_d          = '0;
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      // A bad parity bit is flagged now, and the byte is dropped at STOP
      PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          par_bad_d    = (rx_s != uart_even_parity(shift_q));
          parity_err_d = par_bad_d;
          state_d      = STOP;
        end
      end
`endif

      // Leave at mid-stop-bit so a back-to-back start edge is not missed
      STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          if (!rx_s) begin
            frame_err_d = 1'b0 | 1'b1;
            state_d     = RECOVER;
          end else begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (!par_bad_q) begin
`else
            begin
`endif
              if (f_full) begin
                overrun_err_d = 1'b1;
              end else begin
                rx_dv_d   = 1'b1;
                rx_byte_d = shift_q;
              end
            end
          end
        end
      end

      // A held break gives a single framing error; wait for the line to idle
      RECOVER: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Counter and bit index restart whenever the state changes
    if (state_d != state_q) begin
      clk_cnt_d = '0;
      bit_idx_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rx_byte_q     <= '0;
      rx_dv_q       <= 1'b0;
      busy_q        <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      rx_byte_q     <= rx_byte_d;
      rx_dv_q       <= rx_dv_d;
      busy_q        <= busy_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign Rx_Byte     = rx_byte_q;
  assign Rx_DV       = rx_dv_q;
  assign Rx_Busy     = busy_q;
  assign Frame_Err   = frame_err_q;
  assign Overrun_Err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign Parity_Err  = parity_err_q;
`endif

endmodule
